// File: rtl/znc_flag_register_pkg.sv
// Shared flag bit positions, condition codes and the condition evaluator
// for the ZNC flag register stage.
package znc_flag_register_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    function automatic logic cond_eval(flags_t f, cond_e c);
        logic z, n, cy, v, r;
        z  = f[FLAG_Z];
        n  = f[FLAG_N];
        cy = f[FLAG_C];
        v  = f[FLAG_V];
        r  = 1'b0;
        unique case (c)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = cy;
            COND_CC: r = ~cy;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = cy & ~z;
            COND_LS: r = ~cy | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/znc_flag_register_if.sv
// ALU update, stack control and condition request/response bundle
// between the sequencer (master) and the flag register (slave).
interface znc_flag_register_if #(
    parameter int WIDTH = 16
);
    logic             alu_valid;
    logic             alu_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             a_msb;
    logic             b_msb;
    logic [3:0]       upd_mask;
    logic             push;
    logic             pop;
    logic             cond_req;
    logic [3:0]       cond_code;
    logic             cond_valid;
    logic             cond_true;
    logic [3:0]       flags;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output alu_valid, alu_result, alu_carry, a_msb, b_msb, upd_mask,
        output push, pop, cond_req, cond_code,
        input  alu_ready, cond_valid, cond_true, flags,
        input  stack_full, stack_empty, stack_err
    );

    modport slave (
        input  alu_valid, alu_result, alu_carry, a_msb, b_msb, upd_mask,
        input  push, pop, cond_req, cond_code,
        output alu_ready, cond_valid, cond_true, flags,
        output stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/znc_flag_register_flag_stack.sv
// LIFO of saved flag sets with occupancy count, full/empty status
// and a registered error pulse for illegal push/pop requests.
module flag_stack
    import znc_flag_register_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_push,
    input  logic   i_pop,
    input  flags_t i_flags,
    output flags_t o_top,
    output logic   o_pop_ok,
    output logic   o_full,
    output logic   o_empty,
    output logic   o_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] r_count;
    flags_t        r_mem [DEPTH];
    logic          r_err;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~i_pop & ~o_full;
    assign w_pop_ok  = i_pop & ~i_push & ~o_empty;
    // Simultaneous push+pop is rejected outright rather than swapping the top.
    assign w_err     = (i_push & i_pop)
                     | (i_push & ~i_pop & o_full)
                     | (i_pop & ~i_push & o_empty);
    assign w_wr_idx  = AW'(r_count);
    assign w_rd_idx  = AW'(r_count - CW'(1));

    assign o_top    = r_mem[w_rd_idx];
    assign o_pop_ok = w_pop_ok;
    assign o_err    = r_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_push_ok)
                r_count <= r_count + CW'(1);
            else if (w_pop_ok)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[w_wr_idx] <= i_flags;
    end

endmodule

// File: rtl/znc_flag_register.sv
// Flag register stage: masked ZNCV update, save/restore stack and
// registered branch condition evaluation.
module znc_flag_register
    import znc_flag_register_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    znc_flag_register_if.slave   bus
);
    flags_t r_flags;
    logic   r_cond_valid;
    logic   r_cond_true;

    flags_t w_alu_flags;
    flags_t w_merged;
    flags_t w_top;
    logic   w_accept;
    logic   w_pop_ok;
    logic   w_sign;

    assign w_sign = bus.alu_result[WIDTH-1];

    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_Z] = (bus.alu_result == '0);
        w_alu_flags[FLAG_N] = w_sign;
        w_alu_flags[FLAG_C] = bus.alu_carry;
        w_alu_flags[FLAG_V] = (bus.a_msb == bus.b_msb) & (w_sign != bus.a_msb);
    end

    assign w_merged      = (r_flags & ~bus.upd_mask) | (w_alu_flags & bus.upd_mask);
    assign bus.alu_ready = ~bus.pop;
    assign w_accept      = bus.alu_valid & bus.alu_ready;

    flag_stack #(
        .DEPTH    (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_push   (bus.push),
        .i_pop    (bus.pop),
        .i_flags  (r_flags),
        .o_top    (w_top),
        .o_pop_ok (w_pop_ok),
        .o_full   (bus.stack_full),
        .o_empty  (bus.stack_empty),
        .o_err    (bus.stack_err)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flags      <= '0;
            r_cond_valid <= 1'b0;
            r_cond_true  <= 1'b0;
        end else begin
            if (w_pop_ok)
                r_flags <= w_top;
            else if (w_accept)
                r_flags <= w_merged;
            r_cond_valid <= bus.cond_req;
            r_cond_true  <= bus.cond_req & cond_eval(r_flags, cond_e'(bus.cond_code));
        end
    end

    assign bus.flags      = r_flags;
    assign bus.cond_valid = r_cond_valid;
    assign bus.cond_true  = r_cond_true;

endmodule

// File: tb/tb_znc_flag_register.sv
// Scenario tasks against a reference flag/stack model; condition results
// flow through an expected-value queue.
module tb_znc_flag_register;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    znc_flag_register_if #(.WIDTH(16)) bus ();

    znc_flag_register #(
        .WIDTH       (16),
        .STACK_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    logic       q_cond  [$];

    function automatic logic [3:0] model_alu(logic [15:0] r, logic cy, logic a, logic b);
        logic [3:0] f;
        f[3] = (r == 16'h0000);
        f[2] = r[15];
        f[1] = cy;
        f[0] = (a == b) && (r[15] != a);
        return f;
    endfunction

    function automatic logic model_cond(logic [3:0] f, logic [3:0] code);
        logic z, n, c, v;
        {z, n, c, v} = f;
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid  = 1'b0;
        bus.alu_result = '0;
        bus.alu_carry  = 1'b0;
        bus.a_msb      = 1'b0;
        bus.b_msb      = 1'b0;
        bus.upd_mask   = 4'h0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.cond_req   = 1'b0;
        bus.cond_code  = 4'h0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        m_flags = 4'h0;
        m_stack.delete();
        n_checks++;
        if (bus.flags !== 4'h0 || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0
            || bus.stack_err !== 1'b0 || bus.cond_valid !== 1'b0 || bus.cond_true !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: flags=%h empty=%b full=%b err=%b cv=%b ct=%b, want 0 1 0 0 0 0",
                     bus.flags, bus.stack_empty, bus.stack_full, bus.stack_err,
                     bus.cond_valid, bus.cond_true);
        end
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.alu_ready);
        end
    endtask

    task automatic test_update_eq();
        logic exp;
        bus.alu_valid  = 1'b1;
        bus.alu_result = 16'h0000;
        bus.alu_carry  = 1'b1;
        bus.upd_mask   = 4'hF;
        tick();
        bus.alu_valid = 1'b0;
        m_flags = 4'b1010;
        n_checks++;
        if (bus.flags !== m_flags) begin
            n_fail++;
            $display("FAIL update_zero: flags=%b want %b", bus.flags, m_flags);
        end
        bus.cond_req  = 1'b1;
        bus.cond_code = 4'h0;
        q_cond.push_back(model_cond(m_flags, 4'h0));
        tick();
        bus.cond_req = 1'b0;
        n_checks++;
        if (bus.cond_valid !== 1'b1 || q_cond.size() == 0) begin
            n_fail++;
            $display("FAIL cond_eq_valid: cond_valid=%b want 1", bus.cond_valid);
        end else begin
            exp = q_cond.pop_front();
            n_checks++;
            if (bus.cond_true !== exp || exp !== 1'b1) begin
                n_fail++;
                $display("FAIL cond_eq: cond_true=%b want 1", bus.cond_true);
            end
        end
    endtask

    task automatic test_overflow_back_to_back();
        logic [3:0] codes [3];
        logic       exp;
        codes[0] = 4'hA;
        codes[1] = 4'hB;
        codes[2] = 4'hC;
        bus.alu_valid  = 1'b1;
        bus.alu_result = 16'h8000;
        bus.alu_carry  = 1'b0;
        bus.a_msb      = 1'b0;
        bus.b_msb      = 1'b0;
        bus.upd_mask   = 4'hF;
        tick();
        bus.alu_valid = 1'b0;
        m_flags = 4'b0101;
        n_checks++;
        if (bus.flags !== m_flags) begin
            n_fail++;
            $display("FAIL update_ovf: flags=%b want %b", bus.flags, m_flags);
        end
        for (int i = 0; i < 3; i++) begin
            bus.cond_req  = 1'b1;
            bus.cond_code = codes[i];
            q_cond.push_back(model_cond(m_flags, codes[i]));
            tick();
            n_checks++;
            if (bus.cond_valid !== 1'b1 || q_cond.size() == 0) begin
                n_fail++;
                $display("FAIL cond_b2b_valid[%0d]: cond_valid=%b want 1", i, bus.cond_valid);
            end else begin
                exp = q_cond.pop_front();
                n_checks++;
                if (bus.cond_true !== exp) begin
                    n_fail++;
                    $display("FAIL cond_b2b[%0d] code=%h: cond_true=%b want %b",
                             i, codes[i], bus.cond_true, exp);
                end
            end
        end
        bus.cond_req = 1'b0;
        tick();
        n_checks++;
        if (bus.cond_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cond_idle: cond_valid=%b want 0", bus.cond_valid);
        end
    endtask

    task automatic test_all_codes();
        logic [3:0] fl [3];
        logic       exp;
        fl[0] = 4'b1010;
        fl[1] = 4'b0101;
        fl[2] = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            bus.alu_valid  = 1'b1;
            bus.upd_mask   = 4'hF;
            bus.alu_result = fl[k][3] ? 16'h0000 : (fl[k][2] ? 16'h8001 : 16'h0001);
            bus.alu_carry  = fl[k][1];
            bus.a_msb      = 1'b0;
            bus.b_msb      = fl[k][0] ? 1'b0 : 1'b1;
            m_flags = model_alu(bus.alu_result, bus.alu_carry, bus.a_msb, bus.b_msb);
            tick();
            bus.alu_valid = 1'b0;
            for (int c = 0; c < 16; c++) begin
                bus.cond_req  = 1'b1;
                bus.cond_code = 4'(c);
                q_cond.push_back(model_cond(m_flags, 4'(c)));
                tick();
                exp = (q_cond.size() != 0) ? q_cond.pop_front() : 1'bx;
                n_checks++;
                if (bus.cond_valid !== 1'b1 || bus.cond_true !== exp) begin
                    n_fail++;
                    $display("FAIL cond_code flags=%b code=%h: valid=%b true=%b want 1 %b",
                             m_flags, c, bus.cond_valid, bus.cond_true, exp);
                end
            end
            bus.cond_req = 1'b0;
        end
    endtask

    task automatic test_mask();
        bus.alu_valid  = 1'b1;
        bus.alu_result = 16'h0000;
        bus.alu_carry  = 1'b1;
        bus.a_msb      = 1'b0;
        bus.b_msb      = 1'b0;
        bus.upd_mask   = 4'hF;
        tick();
        bus.alu_result = 16'h1234;
        bus.alu_carry  = 1'b0;
        bus.upd_mask   = 4'b0010;
        tick();
        bus.alu_valid = 1'b0;
        m_flags = 4'b1000;
        n_checks++;
        if (bus.flags !== m_flags) begin
            n_fail++;
            $display("FAIL mask: flags=%b want %b", bus.flags, m_flags);
        end
    endtask

    task automatic test_stack();
        logic [3:0]  saved;
        logic [15:0] r;
        logic        cy, a, b, exp_err;
        for (int i = 0; i < 5; i++) begin
            r  = 16'($urandom_range(0, 65535));
            if (i == 1) r = 16'h0000;
            cy = 1'($urandom_range(0, 1));
            a  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            bus.push       = 1'b1;
            bus.alu_valid  = 1'b1;
            bus.alu_result = r;
            bus.alu_carry  = cy;
            bus.a_msb      = a;
            bus.b_msb      = b;
            bus.upd_mask   = 4'hF;
            exp_err = (m_stack.size() == 4);
            if (!exp_err) m_stack.push_back(m_flags);
            m_flags = model_alu(r, cy, a, b);
            tick();
            n_checks++;
            if (bus.flags !== m_flags || bus.stack_err !== exp_err
                || bus.stack_full !== (m_stack.size() == 4) || bus.stack_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL push[%0d]: flags=%b err=%b full=%b empty=%b want %b %b %b 0",
                         i, bus.flags, bus.stack_err, bus.stack_full, bus.stack_empty,
                         m_flags, exp_err, (m_stack.size() == 4));
            end
        end
        bus.push      = 1'b0;
        bus.alu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.pop = 1'b1;
            #1;
            n_checks++;
            if (bus.alu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL pop_ready[%0d]: alu_ready=%b want 0", i, bus.alu_ready);
            end
            exp_err = (m_stack.size() == 0);
            if (!exp_err) begin
                saved = m_stack.pop_back();
                m_flags = saved;
            end
            tick();
            n_checks++;
            if (bus.flags !== m_flags || bus.stack_err !== exp_err
                || bus.stack_empty !== (m_stack.size() == 0) || bus.stack_full !== 1'b0) begin
                n_fail++;
                $display("FAIL pop[%0d]: flags=%b err=%b empty=%b full=%b want %b %b %b 0",
                         i, bus.flags, bus.stack_err, bus.stack_empty, bus.stack_full,
                         m_flags, exp_err, (m_stack.size() == 0));
            end
        end
        idle();
        tick();
        n_checks++;
        if (bus.stack_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: stack_err=%b want 0", bus.stack_err);
        end
    endtask

    task automatic test_push_pop();
        logic [3:0] saved;
        idle();
        bus.push = 1'b1;
        m_stack.push_back(m_flags);
        saved = m_flags;
        tick();
        bus.push       = 1'b0;
        bus.alu_valid  = 1'b1;
        bus.alu_result = 16'h8000;
        bus.alu_carry  = ~saved[1];
        bus.a_msb      = 1'b0;
        bus.b_msb      = 1'b0;
        bus.upd_mask   = 4'hF;
        m_flags = model_alu(bus.alu_result, bus.alu_carry, 1'b0, 1'b0);
        tick();
        bus.alu_result = 16'h0000;
        bus.push       = 1'b1;
        bus.pop        = 1'b1;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_ready: alu_ready=%b want 0", bus.alu_ready);
        end
        tick();
        n_checks++;
        if (bus.flags !== m_flags || bus.stack_err !== 1'b1
            || bus.stack_empty !== 1'b0 || bus.stack_full !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop: flags=%b err=%b empty=%b full=%b want %b 1 0 0",
                     bus.flags, bus.stack_err, bus.stack_empty, bus.stack_full, m_flags);
        end
        bus.push = 1'b0;
        m_flags = m_stack.pop_back();
        tick();
        n_checks++;
        if (bus.flags !== m_flags || bus.stack_err !== 1'b0 || bus.stack_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_vs_alu: flags=%b err=%b empty=%b want %b 0 1",
                     bus.flags, bus.stack_err, bus.stack_empty, m_flags);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic exp;
        bus.alu_valid  = 1'b1;
        bus.alu_result = 16'h0000;
        bus.alu_carry  = 1'b1;
        bus.upd_mask   = 4'hF;
        tick();
        bus.alu_valid = 1'b0;
        m_flags = 4'b1010;
        bus.push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_stack.push_back(m_flags);
            tick();
        end
        bus.push      = 1'b0;
        bus.cond_req  = 1'b1;
        bus.cond_code = 4'h0;
        q_cond.push_back(model_cond(m_flags, 4'h0));
        tick();
        exp = (q_cond.size() != 0) ? q_cond.pop_front() : 1'bx;
        n_checks++;
        if (bus.cond_valid !== 1'b1 || bus.cond_true !== exp || bus.stack_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b true=%b empty=%b want 1 %b 0",
                     bus.cond_valid, bus.cond_true, bus.stack_empty, exp);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.cond_req = 1'b0;
        m_flags = 4'h0;
        m_stack.delete();
        n_checks++;
        if (bus.stack_empty !== 1'b1 || bus.cond_valid !== 1'b0 || bus.flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: empty=%b cond_valid=%b flags=%b want 1 0 0000",
                     bus.stack_empty, bus.cond_valid, bus.flags);
        end
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        n_checks++;
        if (bus.stack_err !== 1'b1 || bus.flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_discard: err=%b flags=%b want 1 0000", bus.stack_err, bus.flags);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_update_eq();
        test_overflow_back_to_back();
        test_mask();
        test_all_codes();
        test_stack();
        test_push_pop();
        test_reset_mid();
        tick();
        n_checks++;
        if (q_cond.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, want 0", q_cond.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
